ram_port_arbiter: RTL and testbench

Parametrised successor to the fixed two-port RAM hookup in the bicycle computer core. It owns a single-ported register-file store and time-shares it between one write client (mode calculation) and NUM_RD read clients (LED, LCD and future displays). Arbitration is round-robin among readers, with the writer at priority and an anti-starvation override. It also provides a sequenced clear-all sweep used for trip reset.

---
 rtl/ram_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_ram_port_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter
// Single-ported register-file store time-shared between one writer and
// NUM_RD round-robin readers. The writer has priority, but after MAX_WAIT
// consecutive writer grants with a reader waiting, a reader is forced
// through. A clear request runs a one-word-per-cycle sweep that zeroes the
// whole store.
//
// Ports:
//   Clock     - system clock, all state on the rising edge
//   nReset    - synchronous active-low reset
//   wr_req    - writer request, held with wr_addr/wr_data until wr_gnt
//   wr_addr   - write address
//   wr_data   - write data
//   wr_gnt    - one-cycle grant; the write commits on this edge
//   rd_req    - per-reader request, held with the address until granted
//   rd_addr   - reader i address at [i*ADDR_W +: ADDR_W]
//   rd_gnt    - one-hot reader grant pulse
//   rd_valid  - one-hot, high the cycle after the matching rd_gnt bit
//   rd_data   - shared read data, qualified by rd_valid
//   clear_req - single-cycle request to zero the whole store
//   busy      - high while the clear sweep runs
module ram_port_arbiter #(
    parameter int NUM_RD   = 2,
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int DEPTH    = 16,
    parameter int MAX_WAIT = 3
) (
    input  logic                     Clock,
    input  logic                     nReset,
    input  logic                     wr_req,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_gnt,
    input  logic [NUM_RD-1:0]        rd_req,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD-1:0]        rd_gnt,
    output logic [NUM_RD-1:0]        rd_valid,
    output logic [DATA_W-1:0]        rd_data,
    input  logic                     clear_req,
    output logic                     busy
);

    localparam int PTR_W = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    logic [DATA_W-1:0] mem_r [DEPTH];
    state_t            state_r;
    state_t            state_nxt_s;
    logic [PTR_W-1:0]  rr_ptr_r;
    logic [3:0]        wait_cnt_r;
    logic [ADDR_W-1:0] sweep_cnt_r;
    logic [NUM_RD-1:0] rd_valid_r;
    logic [DATA_W-1:0] rd_data_r;

    logic              wr_gnt_s;
    logic [NUM_RD-1:0] rd_gnt_s;
    logic              any_rd_s;
    logic              found_s;
    logic [PTR_W-1:0]  rr_sel_s;
    logic [PTR_W-1:0]  rr_nxt_s;
    logic [ADDR_W-1:0] rd_sel_addr_s;
    logic              rd_in_range_s;
    logic              wr_in_range_s;
    logic              wait_full_s;
    logic              sweep_last_s;
    int                idx_s;

    assign any_rd_s      = |rd_req;
    assign wait_full_s   = (wait_cnt_r == 4'(MAX_WAIT));
    assign sweep_last_s  = (sweep_cnt_r == ADDR_W'(DEPTH - 1));
    assign rd_sel_addr_s = rd_addr[rr_sel_s*ADDR_W +: ADDR_W];
    assign rd_in_range_s = (int'(rd_sel_addr_s) < DEPTH);
    assign wr_in_range_s = (int'(wr_addr) < DEPTH);

    // Round-robin pick: first requesting reader at or above rr_ptr, wrapping.
    always_comb begin
        rr_sel_s = rr_ptr_r;
        found_s  = 1'b0;
        idx_s    = 0;
        for (int k = 0; k < NUM_RD; k++) begin
            idx_s = (int'(rr_ptr_r) + k) % NUM_RD;
            if (!found_s && rd_req[idx_s]) begin
                rr_sel_s = PTR_W'(idx_s);
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
        if (int'(rr_sel_s) == NUM_RD - 1) begin
            rr_nxt_s = '0;
        end else begin
            rr_nxt_s = rr_sel_s + PTR_W'(1);
        end
    end

    // Arbitration FSM next state and grants; clear beats everything.
    always_comb begin
        state_nxt_s = state_r;
        wr_gnt_s    = 1'b0;
        rd_gnt_s    = '0;
        case (state_r)
            ST_ARB: begin
                if (clear_req) begin
                    state_nxt_s = ST_CLEAR;
                end else if (wait_full_s && any_rd_s) begin
                    rd_gnt_s = NUM_RD'(1'b1) << rr_sel_s;
                end else if (wr_req) begin
                    wr_gnt_s = 1'b1;
                end else if (any_rd_s) begin
                    rd_gnt_s = NUM_RD'(1'b1) << rr_sel_s;
                end else begin
                    state_nxt_s = ST_ARB;
                end
            end
            ST_CLEAR: begin
                if (sweep_last_s) begin
                    state_nxt_s = ST_ARB;
                end else begin
                    state_nxt_s = ST_CLEAR;
                end
            end
            default: begin
                state_nxt_s = ST_ARB;
            end
        endcase
    end

    // State, store, read pipeline and fairness counters.
    always_ff @(posedge Clock) begin
        if (!nReset) begin
            state_r     <= ST_ARB;
            rr_ptr_r    <= '0;
            wait_cnt_r  <= 4'd0;
            sweep_cnt_r <= '0;
            rd_valid_r  <= '0;
            rd_data_r   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            state_r <= state_nxt_s;

            // Sweep and normal writes never coincide: no grants in CLEAR.
            if (state_r == ST_CLEAR) begin
                mem_r[sweep_cnt_r[IDX_W-1:0]] <= '0;
                sweep_cnt_r <= sweep_last_s ? '0 : sweep_cnt_r + ADDR_W'(1);
            end else begin
                sweep_cnt_r <= '0;
                if (wr_gnt_s && wr_in_range_s) begin
                    mem_r[wr_addr[IDX_W-1:0]] <= wr_data;
                end
            end

            rd_valid_r <= rd_gnt_s;
            if (|rd_gnt_s) begin
                rd_data_r <= rd_in_range_s ? mem_r[rd_sel_addr_s[IDX_W-1:0]] : '0;
                rr_ptr_r  <= rr_nxt_s;
            end else begin
                rd_data_r <= rd_data_r;
                rr_ptr_r  <= rr_ptr_r;
            end

            // Count writer grants that overtook a waiting reader.
            if (state_r == ST_ARB) begin
                if ((|rd_gnt_s) || !any_rd_s) begin
                    wait_cnt_r <= 4'd0;
                end else if (wr_gnt_s && !wait_full_s) begin
                    wait_cnt_r <= wait_cnt_r + 4'd1;
                end else begin
                    wait_cnt_r <= wait_cnt_r;
                end
            end else begin
                wait_cnt_r <= wait_cnt_r;
            end
        end
    end

    assign wr_gnt   = wr_gnt_s;
    assign rd_gnt   = rd_gnt_s;
    assign rd_valid = rd_valid_r;
    assign rd_data  = rd_data_r;
    assign busy     = (state_r == ST_CLEAR);

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter. Two instances share the stimulus:
// u_dut (DEPTH=16) for the main features and u_dut12 (DEPTH=12) for the
// out-of-range address behaviour. Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_ram_port_arbiter;

    logic        Clock = 1'b0;
    logic        nReset;
    logic        wr_req;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [1:0]  rd_req;
    logic [7:0]  rd_addr;
    logic        clear_req;

    logic        wr_gnt,   wr_gnt_12;
    logic [1:0]  rd_gnt,   rd_gnt_12;
    logic [1:0]  rd_valid, rd_valid_12;
    logic [15:0] rd_data,  rd_data_12;
    logic        busy,     busy_12;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 Clock = ~Clock;

    ram_port_arbiter #(
        .NUM_RD(2), .DATA_W(16), .ADDR_W(4), .DEPTH(16), .MAX_WAIT(3)
    ) u_dut (
        .Clock(Clock), .nReset(nReset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
        .rd_valid(rd_valid), .rd_data(rd_data),
        .clear_req(clear_req), .busy(busy)
    );

    ram_port_arbiter #(
        .NUM_RD(2), .DATA_W(16), .ADDR_W(4), .DEPTH(12), .MAX_WAIT(3)
    ) u_dut12 (
        .Clock(Clock), .nReset(nReset),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt_12),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt_12),
        .rd_valid(rd_valid_12), .rd_data(rd_data_12),
        .clear_req(clear_req), .busy(busy_12)
    );

    task automatic next_cycle();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_reset();
        nReset    = 1'b0;
        wr_req    = 1'b0;
        wr_addr   = 4'h0;
        wr_data   = 16'h0000;
        rd_req    = 2'b00;
        rd_addr   = 8'h00;
        clear_req = 1'b0;
        next_cycle();
        nReset = 1'b1;
    endtask

    // Single uncontended write, granted in the cycle it is presented.
    task automatic do_write(input logic [3:0] a, input logic [15:0] d);
        wr_req  = 1'b1;
        wr_addr = a;
        wr_data = d;
        next_cycle();
        wr_req  = 1'b0;
    endtask

    // Single uncontended read; returns what both instances present one
    // cycle after the grant.
    task automatic do_read(input int r, input logic [3:0] a,
                           output logic [1:0] v16, output logic [15:0] d16,
                           output logic [1:0] v12, output logic [15:0] d12);
        rd_req           = 2'b00;
        rd_req[r]        = 1'b1;
        rd_addr[r*4 +: 4] = a;
        next_cycle();
        rd_req = 2'b00;
        @(negedge Clock);
        v16 = rd_valid;
        d16 = rd_data;
        v12 = rd_valid_12;
        d12 = rd_data_12;
        next_cycle();
    endtask

    task automatic test_reset();
        logic [1:0]  v, v12;
        logic [15:0] d, d12;
        do_reset();
        @(negedge Clock);
        n_checks++;
        if ({wr_gnt, rd_gnt, rd_valid, busy} !== 6'b000000) begin
            n_fail++;
            $display("FAIL reset.ctrl got=%b exp=%b", {wr_gnt, rd_gnt, rd_valid, busy}, 6'b000000);
        end
        n_checks++;
        if (rd_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset.rd_data got=%h exp=%h", rd_data, 16'h0000);
        end
        next_cycle();
        do_read(0, 4'h3, v, d, v12, d12);
        n_checks++;
        if (v !== 2'b01 || d !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset.store got=%b/%h exp=%b/%h", v, d, 2'b01, 16'h0000);
        end
    endtask

    task automatic test_write_read();
        do_reset();
        wr_req  = 1'b1;
        wr_addr = 4'h5;
        wr_data = 16'h1234;
        @(negedge Clock);
        n_checks++;
        if (wr_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_rd.wr_gnt got=%b exp=%b", wr_gnt, 1'b1);
        end
        next_cycle();
        wr_req       = 1'b0;
        rd_req       = 2'b10;
        rd_addr[7:4] = 4'h5;
        @(negedge Clock);
        n_checks++;
        if (rd_gnt !== 2'b10) begin
            n_fail++;
            $display("FAIL wr_rd.rd_gnt got=%b exp=%b", rd_gnt, 2'b10);
        end
        next_cycle();
        rd_req = 2'b00;
        @(negedge Clock);
        n_checks++;
        if (rd_valid !== 2'b10 || rd_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL wr_rd.data got=%b/%h exp=%b/%h", rd_valid, rd_data, 2'b10, 16'h1234);
        end
        next_cycle();
        @(negedge Clock);
        n_checks++;
        if (rd_valid !== 2'b00 || rd_data !== 16'h1234) begin
            n_fail++;
            $display("FAIL wr_rd.hold got=%b/%h exp=%b/%h", rd_valid, rd_data, 2'b00, 16'h1234);
        end
        next_cycle();
    endtask

    task automatic test_round_robin();
        logic [1:0]  exp_gnt [4];
        logic [15:0] exp_dat [4];
        exp_gnt = '{2'b01, 2'b10, 2'b01, 2'b10};
        exp_dat = '{16'hAAAA, 16'h5555, 16'hAAAA, 16'h5555};
        do_reset();
        do_write(4'h2, 16'hAAAA);
        do_write(4'h3, 16'h5555);
        rd_req  = 2'b11;
        rd_addr = {4'h3, 4'h2};
        for (int c = 0; c < 5; c++) begin
            if (c == 4) begin
                rd_req = 2'b00;
            end
            @(negedge Clock);
            if (c < 4) begin
                n_checks++;
                if (rd_gnt !== exp_gnt[c]) begin
                    n_fail++;
                    $display("FAIL rr.gnt[%0d] got=%b exp=%b", c, rd_gnt, exp_gnt[c]);
                end
            end
            if (c > 0) begin
                n_checks++;
                if (rd_valid !== exp_gnt[c-1] || rd_data !== exp_dat[c-1]) begin
                    n_fail++;
                    $display("FAIL rr.valid[%0d] got=%b/%h exp=%b/%h", c, rd_valid, rd_data,
                             exp_gnt[c-1], exp_dat[c-1]);
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_starvation();
        logic       exp_w;
        logic [1:0] exp_r;
        logic [1:0] prev_r;
        do_reset();
        wr_req       = 1'b1;
        wr_addr      = 4'h7;
        wr_data      = 16'h0700;
        rd_req       = 2'b01;
        rd_addr[3:0] = 4'h7;
        prev_r       = 2'b00;
        // Three writer grants, then the reader is forced, repeating.
        for (int c = 0; c < 8; c++) begin
            exp_w = (c % 4 != 3);
            exp_r = (c % 4 == 3) ? 2'b01 : 2'b00;
            @(negedge Clock);
            n_checks++;
            if (wr_gnt !== exp_w || rd_gnt !== exp_r) begin
                n_fail++;
                $display("FAIL starve.gnt[%0d] got=%b/%b exp=%b/%b", c, wr_gnt, rd_gnt, exp_w, exp_r);
            end
            if (prev_r != 2'b00) begin
                n_checks++;
                if (rd_valid !== prev_r || rd_data !== 16'h0700) begin
                    n_fail++;
                    $display("FAIL starve.valid[%0d] got=%b/%h exp=%b/%h", c, rd_valid, rd_data,
                             prev_r, 16'h0700);
                end
            end
            prev_r = exp_r;
            next_cycle();
        end
        wr_req = 1'b0;
        rd_req = 2'b00;
        next_cycle();
    endtask

    task automatic test_clear();
        int          cnt;
        logic [1:0]  v, v12;
        logic [15:0] d, d12;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            do_write(4'(i), 16'h1000 + 16'(i));
        end
        do_read(1, 4'h9, v, d, v12, d12);
        n_checks++;
        if (v !== 2'b10 || d !== 16'h1009) begin
            n_fail++;
            $display("FAIL clear.prefill got=%b/%h exp=%b/%h", v, d, 2'b10, 16'h1009);
        end
        clear_req = 1'b1;
        wr_req    = 1'b1;
        wr_addr   = 4'h1;
        wr_data   = 16'hBEEF;
        @(negedge Clock);
        n_checks++;
        if (wr_gnt !== 1'b0 || rd_gnt !== 2'b00 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear.req_cycle got=%b/%b/%b exp=0/00/0", wr_gnt, rd_gnt, busy);
        end
        next_cycle();
        clear_req = 1'b0;
        cnt = 0;
        @(negedge Clock);
        while (busy === 1'b1 && cnt < 40) begin
            cnt++;
            n_checks++;
            if (wr_gnt !== 1'b0) begin
                n_fail++;
                $display("FAIL clear.gnt_in_sweep got=%b exp=%b", wr_gnt, 1'b0);
            end
            next_cycle();
            @(negedge Clock);
        end
        n_checks++;
        if (cnt != 16) begin
            n_fail++;
            $display("FAIL clear.busy_len got=%0d exp=%0d", cnt, 16);
        end
        n_checks++;
        if (wr_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL clear.wr_after got=%b exp=%b", wr_gnt, 1'b1);
        end
        next_cycle();
        wr_req = 1'b0;
        do_read(0, 4'h0, v, d, v12, d12);
        n_checks++;
        if (v !== 2'b01 || d !== 16'h0000) begin
            n_fail++;
            $display("FAIL clear.addr0 got=%b/%h exp=%b/%h", v, d, 2'b01, 16'h0000);
        end
        do_read(0, 4'h1, v, d, v12, d12);
        n_checks++;
        if (v !== 2'b01 || d !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL clear.addr1 got=%b/%h exp=%b/%h", v, d, 2'b01, 16'hBEEF);
        end
        do_read(1, 4'hF, v, d, v12, d12);
        n_checks++;
        if (v !== 2'b10 || d !== 16'h0000) begin
            n_fail++;
            $display("FAIL clear.addr15 got=%b/%h exp=%b/%h", v, d, 2'b10, 16'h0000);
        end
    endtask

    task automatic test_reset_mid_clear();
        logic [1:0]  v, v12;
        logic [15:0] d, d12;
        do_reset();
        do_write(4'hA, 16'hCAFE);
        clear_req = 1'b1;
        next_cycle();
        clear_req = 1'b0;
        // Now in sweep cycle 0; advance to sweep cycle 7.
        for (int i = 0; i < 7; i++) begin
            next_cycle();
        end
        @(negedge Clock);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midclr.busy_before got=%b exp=%b", busy, 1'b1);
        end
        next_cycle();
        nReset = 1'b0;
        next_cycle();
        nReset = 1'b1;
        @(negedge Clock);
        n_checks++;
        if ({busy, wr_gnt, rd_gnt, rd_valid} !== 6'b000000 || rd_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL midclr.outs got=%b/%h exp=%b/%h", {busy, wr_gnt, rd_gnt, rd_valid},
                     rd_data, 6'b000000, 16'h0000);
        end
        next_cycle();
        do_read(0, 4'hA, v, d, v12, d12);
        n_checks++;
        if (v !== 2'b01 || d !== 16'h0000) begin
            n_fail++;
            $display("FAIL midclr.addr10 got=%b/%h exp=%b/%h", v, d, 2'b01, 16'h0000);
        end
    endtask

    task automatic test_reset_pending_read();
        logic [1:0]  v, v12;
        logic [15:0] d, d12;
        do_reset();
        do_write(4'h4, 16'h4444);
        do_read(0, 4'h4, v, d, v12, d12);
        n_checks++;
        if (v !== 2'b01 || d !== 16'h4444) begin
            n_fail++;
            $display("FAIL rstrd.pre got=%b/%h exp=%b/%h", v, d, 2'b01, 16'h4444);
        end
        rd_req       = 2'b01;
        rd_addr[3:0] = 4'h4;
        nReset       = 1'b0;
        next_cycle();
        nReset = 1'b1;
        rd_req = 2'b00;
        @(negedge Clock);
        n_checks++;
        if (rd_valid !== 2'b00 || rd_data !== 16'h0000) begin
            n_fail++;
            $display("FAIL rstrd.suppress got=%b/%h exp=%b/%h", rd_valid, rd_data, 2'b00, 16'h0000);
        end
        next_cycle();
    endtask

    task automatic test_out_of_range();
        logic [1:0]  v, v12;
        logic [15:0] d, d12;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            do_write(4'(i), 16'h2000 + 16'(i));
        end
        do_read(0, 4'hB, v, d, v12, d12);
        n_checks++;
        if (v12 !== 2'b01 || d12 !== 16'h200B) begin
            n_fail++;
            $display("FAIL oor.addr11 got=%b/%h exp=%b/%h", v12, d12, 2'b01, 16'h200B);
        end
        do_read(0, 4'hF, v, d, v12, d12);
        n_checks++;
        if (v12 !== 2'b01 || d12 !== 16'h0000) begin
            n_fail++;
            $display("FAIL oor.read got=%b/%h exp=%b/%h", v12, d12, 2'b01, 16'h0000);
        end
        wr_req  = 1'b1;
        wr_addr = 4'hF;
        wr_data = 16'hFFFF;
        @(negedge Clock);
        n_checks++;
        if (wr_gnt_12 !== 1'b1) begin
            n_fail++;
            $display("FAIL oor.wr_gnt got=%b exp=%b", wr_gnt_12, 1'b1);
        end
        next_cycle();
        wr_req = 1'b0;
        for (int i = 0; i < 12; i++) begin
            do_read(1, 4'(i), v, d, v12, d12);
            n_checks++;
            if (v12 !== 2'b10 || d12 !== 16'h2000 + 16'(i)) begin
                n_fail++;
                $display("FAIL oor.keep[%0d] got=%b/%h exp=%b/%h", i, v12, d12, 2'b10,
                         16'h2000 + 16'(i));
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_round_robin();
        test_starvation();
        test_clear();
        test_reset_mid_clear();
        test_reset_pending_read();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
